// File: rtl/ibusif_pkg.sv
// Shared types and constants for the instruction-bus prefetch queue.
package ibusif_pkg;

  localparam logic [1:0] HSIZE_16 = 2'b01;
  localparam logic [1:0] HSIZE_32 = 2'b10;

  // Only bit 0 of pop_size is decoded: set takes one halfword, clear takes two.
  localparam logic [1:0] POP_SIZE_16 = 2'b01;
  localparam logic [1:0] POP_SIZE_32 = 2'b10;

  typedef struct packed {
    logic        err;
    logic [15:0] hw;
  } ifq_entry_t;

  function automatic logic [31:0] seq_addr(input logic [31:0] a);
    return {a[31:2] + 30'd1, 2'b00};
  endfunction

endpackage

// File: rtl/ifq_hw.sv
// Circular halfword FIFO with 1/2-entry push and pop, clear, and a 2-entry head view.
module ifq_hw
  import ibusif_pkg::*;
#(
  parameter  int QDEPTH = 4,
  localparam int AW     = $clog2(QDEPTH),
  localparam int CW     = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic [1:0]    push_n,
  input  ifq_entry_t    push0,
  input  ifq_entry_t    push1,
  input  logic [1:0]    pop_n,
  output logic [CW-1:0] count,
  output ifq_entry_t    head0,
  output ifq_entry_t    head1
);

  ifq_entry_t    r_mem [QDEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] w_wr1;
  logic [AW-1:0] w_rd1;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  assign w_wr1 = r_wr + AW'(1);
  assign w_rd1 = r_rd + AW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < QDEPTH; i++) r_mem[i] <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (push_n != 2'd0) r_mem[r_wr]  <= push0;
      if (push_n == 2'd2) r_mem[w_wr1] <= push1;
      r_wr  <= r_wr + AW'(push_n);
      r_rd  <= r_rd + AW'(pop_n);
      r_cnt <= r_cnt + CW'(push_n) - CW'(pop_n);
    end
  end

  assign count = r_cnt;
  assign head0 = r_mem[r_rd];
  assign head1 = r_mem[w_rd1];

endmodule

// File: rtl/ibusif_pq.sv
// Instruction-bus fetch interface with halfword prefetch queue and jump redirect.
// Optional IBUSIF_PQ_BYPASS_EN forwards responses straight to the head when the queue is empty.
module ibusif_pq
  import ibusif_pkg::*;
#(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jmp_req,
  input  logic [31:0] jmp_addr,
  output logic [1:0]  vld_size,
  output logic [31:0] data,
  output logic        bus_err,
  input  logic        pop,
  input  logic [1:0]  pop_size,
  output logic [31:0] haddr,
  output logic [1:0]  hsize,
  output logic        htrans,
  output logic        hprot,
  output logic        hwrite,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hresp,
  input  logic        hready
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]   r_addr;
  logic          r_outst;
  logic          r_cancel;
  logic          r_osize32;
  logic          r_halted;

  logic [31:0]   w_jaddr;
  logic [CW-1:0] w_cnt, w_free, w_need, w_resv, w_vcnt;
  logic          w_done, w_err, w_pop_ok;
  logic [1:0]    w_rsp_n, w_pop_n, w_fpush_n, w_fpop_n;
  ifq_entry_t    w_rsp0, w_rsp1, w_head0, w_head1, w_v0, w_v1, w_fpush0, w_fpush1;

  assign w_jaddr = jmp_addr & 32'hFFFF_FFFE;
  assign haddr   = jmp_req ? w_jaddr : r_addr;
  assign hsize   = haddr[1] ? HSIZE_16 : HSIZE_32;
  assign hprot   = 1'b0;
  assign hwrite  = 1'b0;
  assign hwdata  = '0;

  // Credit uses the registered fill level; a pop this cycle earns nothing.
  assign w_free = CW'(QDEPTH) - w_cnt;
  assign w_need = haddr[1] ? CW'(1) : CW'(2);
  assign w_resv = (r_outst && !r_cancel) ? (r_osize32 ? CW'(2) : CW'(1)) : '0;
  assign w_done = r_outst && hready && !r_cancel && !jmp_req;
  assign w_err  = w_done && hresp;
  assign htrans = hready && (jmp_req || (!r_halted && !w_err && (w_free >= w_need + w_resv)));

  always_comb begin
    w_rsp_n = 2'd0;
    w_rsp0  = '0;
    w_rsp1  = '0;
    if (w_done) begin
      w_rsp_n = r_osize32 ? 2'd2 : 2'd1;
      if (hresp) begin
        w_rsp0.err = 1'b1;
        w_rsp1.err = r_osize32;
      end else if (r_osize32) begin
        w_rsp0.hw = hrdata[15:0];
        w_rsp1.hw = hrdata[31:16];
      end else begin
        w_rsp0.hw = hrdata[31:16];
      end
    end
  end

  always_comb begin
    w_v0   = w_head0;
    w_v1   = w_head1;
    w_vcnt = w_cnt;
`ifdef IBUSIF_PQ_BYPASS_EN
    if (w_cnt == '0 && w_rsp_n != 2'd0) begin
      w_v0   = w_rsp0;
      w_v1   = w_rsp1;
      w_vcnt = CW'(w_rsp_n);
    end
`endif
  end

  assign vld_size = (w_vcnt >= CW'(2)) ? 2'd2 : w_vcnt[1:0];
  assign data     = {(vld_size == 2'd2) ? w_v1.hw : 16'h0, (vld_size != 2'd0) ? w_v0.hw : 16'h0};
  assign bus_err  = ((vld_size != 2'd0) && w_v0.err) || ((vld_size == 2'd2) && w_v1.err);

  assign w_pop_ok = (pop_size[0] == POP_SIZE_16[0]) ? (vld_size != 2'd0) : (vld_size == 2'd2);
  assign w_pop_n  = (pop && !jmp_req && w_pop_ok) ? ((pop_size[0] == POP_SIZE_16[0]) ? 2'd1 : 2'd2) : 2'd0;

  // Bypassed halfwords that were popped this cycle never enter the FIFO.
  always_comb begin
    w_fpush_n = w_rsp_n;
    w_fpush0  = w_rsp0;
    w_fpush1  = w_rsp1;
    w_fpop_n  = w_pop_n;
`ifdef IBUSIF_PQ_BYPASS_EN
    if (w_cnt == '0 && w_rsp_n != 2'd0) begin
      w_fpop_n  = 2'd0;
      w_fpush_n = w_rsp_n - w_pop_n;
      w_fpush0  = (w_pop_n == 2'd1) ? w_rsp1 : w_rsp0;
    end
`endif
  end

  ifq_hw #(.QDEPTH(QDEPTH)) u_ifq (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (jmp_req),
    .push_n (w_fpush_n),
    .push0  (w_fpush0),
    .push1  (w_fpush1),
    .pop_n  (w_fpop_n),
    .count  (w_cnt),
    .head0  (w_head0),
    .head1  (w_head1)
  );

  // A jump during a stalled data phase marks that response for discard.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr    <= RESET_PC;
      r_outst   <= 1'b0;
      r_cancel  <= 1'b0;
      r_osize32 <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      if (jmp_req)     r_addr <= htrans ? seq_addr(w_jaddr) : w_jaddr;
      else if (htrans) r_addr <= seq_addr(r_addr);
      if (hready) begin
        r_outst   <= htrans;
        r_cancel  <= 1'b0;
        r_osize32 <= (hsize == HSIZE_32);
      end else if (jmp_req) begin
        r_cancel  <= 1'b1;
      end
      if (jmp_req)    r_halted <= 1'b0;
      else if (w_err) r_halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ibusif_pq.sv
// Randomized self-checking bench for ibusif_pq against a queue-based reference model.
// Follows IBUSIF_PQ_BYPASS_EN in the model when it is defined.
module tb_ibusif_pq;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        err;
    logic [15:0] hw;
  } hwEntry_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        jmpReq;
  logic [31:0] jmpAddr;
  logic [1:0]  vldSize;
  logic [31:0] dataOut;
  logic        busErr;
  logic        popReq;
  logic [1:0]  popSize;
  logic [31:0] haddr;
  logic [1:0]  hsize;
  logic        htrans, hprot, hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hresp, hready;

  int checks = 0;
  int errors = 0;

  // reference model state
  hwEntry_t    mQ[$];
  logic [31:0] mPc;
  logic        mBusy, mDrop, mHalted;
  logic [31:0] mBAddr;

  // bus slave state
  logic        sPend, sErr, sErrStage;
  logic [31:0] sAddr;
  int          pReady, pErr, stallReq;
  logic [31:0] forceErrAddr;

  always #5 clk = ~clk;

  ibusif_pq #(.QDEPTH(DEPTH), .RESET_PC(32'h0000_0100)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .jmp_req  (jmpReq),
    .jmp_addr (jmpAddr),
    .vld_size (vldSize),
    .data     (dataOut),
    .bus_err  (busErr),
    .pop      (popReq),
    .pop_size (popSize),
    .haddr    (haddr),
    .hsize    (hsize),
    .htrans   (htrans),
    .hprot    (hprot),
    .hwrite   (hwrite),
    .hwdata   (hwdata),
    .hrdata   (hrdata),
    .hresp    (hresp),
    .hready   (hready)
  );

  // Memory image: every halfword address carries a distinct value.
  function automatic logic [15:0] memHw(input logic [31:0] a);
    return a[16:1] ^ 16'h3C5A;
  endfunction

  function automatic logic [31:0] nextAddr(input logic [31:0] a);
    return (a & 32'hFFFF_FFFC) + 32'd4;
  endfunction

  function automatic hwEntry_t mkEnt(input logic e, input logic [15:0] v);
    hwEntry_t x;
    x.err = e;
    x.hw  = e ? 16'h0 : v;
    return x;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One full clock cycle: drive, check combinational outputs, then advance model and slave.
  task automatic applyStimulus();
    logic [31:0] eHaddr;
    int          eNeed, eRes, eVld, n;
    logic        eDone, eErr, eHtrans, eBusErr;
    logic [31:0] eData, mask;
    hwEntry_t    resp[$];
    hwEntry_t    vis[$];
    logic        dutHtrans;
    logic [31:0] dutHaddr;

    if (sPend && sErr) begin
      hresp  = 1'b1;
      hready = sErrStage;
    end else if (sPend && stallReq > 0) begin
      hresp  = 1'b0;
      hready = 1'b0;
    end else begin
      hresp  = 1'b0;
      hready = ($urandom_range(0, 99) < pReady);
    end
    if (sPend && !sErr)
      hrdata = sAddr[1] ? {memHw(sAddr), 16'hDEAD} : {memHw(sAddr + 32'd2), memHw(sAddr)};
    else
      hrdata = $urandom;
    #4;

    eHaddr  = jmpReq ? {jmpAddr[31:1], 1'b0} : mPc;
    eNeed   = eHaddr[1] ? 1 : 2;
    eRes    = (mBusy && !mDrop) ? (mBAddr[1] ? 1 : 2) : 0;
    eDone   = mBusy && hready && !mDrop && !jmpReq;
    eErr    = eDone && hresp;
    eHtrans = hready && (jmpReq || (!mHalted && !eErr && (DEPTH - mQ.size()) >= eNeed + eRes));
    if (eDone) begin
      resp.push_back(mkEnt(hresp, memHw(mBAddr)));
      if (!mBAddr[1]) resp.push_back(mkEnt(hresp, memHw(mBAddr + 32'd2)));
    end
    vis = mQ;
`ifdef IBUSIF_PQ_BYPASS_EN
    if (mQ.size() == 0) vis = resp;
`endif
    eVld    = (vis.size() >= 2) ? 2 : vis.size();
    eData   = 32'h0;
    eBusErr = 1'b0;
    if (eVld >= 1) begin eData[15:0]  = vis[0].hw; eBusErr = vis[0].err; end
    if (eVld == 2) begin eData[31:16] = vis[1].hw; eBusErr = eBusErr | vis[1].err; end
    mask = (eVld == 2) ? 32'hFFFF_FFFF : (eVld == 1) ? 32'h0000_FFFF : 32'h0;

    checkOutput("htrans", {31'h0, htrans}, {31'h0, eHtrans});
    checkOutput("haddr", haddr, eHaddr);
    checkOutput("hsize", {30'h0, hsize}, eHaddr[1] ? 32'd1 : 32'd2);
    checkOutput("vld_size", {30'h0, vldSize}, eVld);
    checkOutput("data", dataOut & mask, eData);
    checkOutput("bus_err", {31'h0, busErr}, {31'h0, eBusErr});
    checkOutput("fixed", {hwdata[30:0] | {30'h0, hprot, hwrite}}, 32'h0);
    dutHtrans = htrans;
    dutHaddr  = haddr;

    @(posedge clk);
    #1;

    if (jmpReq) begin
      mQ.delete();
      mHalted = 1'b0;
      mPc     = eHtrans ? nextAddr(eHaddr) : eHaddr;
    end else begin
      foreach (resp[i]) mQ.push_back(resp[i]);
      n = popSize[0] ? 1 : 2;
      if (popReq && ((n == 1 && eVld >= 1) || (n == 2 && eVld == 2)))
        repeat (n) void'(mQ.pop_front());
      if (eErr) mHalted = 1'b1;
      if (eHtrans) mPc = nextAddr(mPc);
    end
    if (hready) begin
      mBusy  = eHtrans;
      mBAddr = eHaddr;
      mDrop  = 1'b0;
    end else if (jmpReq) begin
      mDrop = 1'b1;
    end

    if (hready) begin
      sPend     = dutHtrans;
      sAddr     = dutHaddr;
      sErr      = dutHtrans && ((dutHaddr == forceErrAddr) || ($urandom_range(0, 99) < pErr));
      sErrStage = 1'b0;
    end else begin
      if (sPend && sErr) sErrStage = 1'b1;
      if (sPend && !sErr && stallReq > 0) stallReq--;
    end
  endtask

  task automatic runCycles(input int cnt, input logic doPop, input logic [1:0] psz);
    for (int i = 0; i < cnt; i++) begin
      jmpReq  = 1'b0;
      popReq  = doPop;
      popSize = psz;
      applyStimulus();
    end
  endtask

  task automatic jumpTo(input logic [31:0] a, input logic doPop, input logic [1:0] psz);
    jmpReq  = 1'b1;
    jmpAddr = a;
    popReq  = doPop;
    popSize = psz;
    applyStimulus();
    jmpReq  = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; jmpReq = 1'b0; jmpAddr = 32'h0; popReq = 1'b0; popSize = 2'b01;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
    mPc = 32'h100; mBusy = 1'b0; mDrop = 1'b0; mHalted = 1'b0; mBAddr = 32'h0;
    sPend = 1'b0; sErr = 1'b0; sErrStage = 1'b0; sAddr = 32'h0;
    pReady = 100; pErr = 0; stallReq = 0; forceErrAddr = 32'h1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_haddr", haddr, 32'h100);
    checkOutput("rst_htrans", {31'h0, htrans}, 32'h1);
    checkOutput("rst_vld", {30'h0, vldSize}, 32'h0);
    checkOutput("rst_data", dataOut, 32'h0);
    checkOutput("rst_buserr", {31'h0, busErr}, 32'h0);
    rstn = 1'b1;

    runCycles(8, 1'b0, 2'b01);
    runCycles(1, 1'b1, 2'b00);
    runCycles(1, 1'b0, 2'b01);
    jumpTo(32'h202, 1'b1, 2'b01);
    runCycles(6, 1'b0, 2'b01);

    forceErrAddr = 32'h108;
    jumpTo(32'h100, 1'b0, 2'b01);
    runCycles(14, 1'b1, 2'b01);
    forceErrAddr = 32'h1;
    jumpTo(32'h300, 1'b0, 2'b01);
    runCycles(8, 1'b1, 2'b01);

    jumpTo(32'h500, 1'b0, 2'b01);
    stallReq = 3;
    runCycles(8, 1'b0, 2'b01);

    jumpTo(32'hFFFF_FFFC, 1'b0, 2'b01);
    runCycles(5, 1'b1, 2'b00);

    jumpTo(32'h400, 1'b0, 2'b01);
    runCycles(6, 1'b1, 2'b00);

    pReady = 75;
    pErr   = 4;
    for (int i = 0; i < 3000; i++) begin
      jmpReq  = ($urandom_range(0, 99) < 3);
      jmpAddr = $urandom;
      popReq  = ($urandom_range(0, 99) < 60);
      popSize = 2'($urandom_range(0, 3));
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
